// File: rtl/header_wr_ctrl_pkg.sv
// Shared constants for the status CPLD header write side: offset indices,
// command bits and the memory-port FSM encoding.
package header_wr_ctrl_pkg;

  localparam int OFS_INTERCONN = 5;
  localparam int OFS_KEYDIS    = 6;
  localparam int OFS_CMD       = 7;
  localparam int OFS_MADDR     = 8;
  localparam int OFS_MWDATA    = 9;

  localparam int CMD_RD  = 0;
  localparam int CMD_WR  = 1;
  localparam int CMD_CLR = 7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  function automatic logic is_onehot16(input logic [15:0] v);
    return (v != 16'h0000) && ((v & (v - 16'h0001)) == 16'h0000);
  endfunction

endpackage

// File: rtl/header_wr_decode.sv
// Host write decode: one commit per write qualifier rise, gated by a
// one-hot offset select, fanned out as per-register write strobes.
module header_wr_decode
  import header_wr_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        port_cs_i,
  input  logic        rd_wr_i,
  input  logic [15:0] offset_sel_i,
  output logic        wr_interconn_o,
  output logic        wr_keydis_o,
  output logic        wr_cmd_o,
  output logic        wr_maddr_o,
  output logic        wr_mwdata_o
);

  logic wq;
  logic wq_q;
  logic commit;

  assign wq = port_cs_i & ~rd_wr_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) wq_q <= 1'b0;
    else       wq_q <= wq;
  end

  // A long PORT_CS hold yields a single commit on the rising edge only.
  assign commit = wq & ~wq_q & is_onehot16(offset_sel_i);

  assign wr_interconn_o = commit & offset_sel_i[OFS_INTERCONN];
  assign wr_keydis_o    = commit & offset_sel_i[OFS_KEYDIS];
  assign wr_cmd_o       = commit & offset_sel_i[OFS_CMD];
  assign wr_maddr_o     = commit & offset_sel_i[OFS_MADDR];
  assign wr_mwdata_o    = commit & offset_sel_i[OFS_MWDATA];

endmodule

// File: rtl/header_wr_ctrl.sv
// Header write-side registers plus the request/acknowledge FSM that drives
// the external memory port.
module header_wr_ctrl
  import header_wr_ctrl_pkg::*;
#(
  parameter logic [7:0] INTERCONN_RST = 8'h00,
  parameter logic [7:0] KEYDIS_RST    = 8'h00,
  parameter int         TIMEOUT_CYC   = 255
) (
  input  logic        SYSCLK,
  input  logic        RESET,
  input  logic        PORT_CS,
  input  logic [15:0] OFFSET_SEL,
  input  logic        RD_WR,
  input  logic [7:0]  DIN,
  input  logic        MEM_ACK,
  input  logic [7:0]  MEM_RD_DATA,
  output logic [7:0]  URT_INTERCONN_OUT,
  output logic [7:0]  URT_KEY_DISABLE_OUT,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [7:0]  MEM_ADDR,
  output logic [7:0]  MEM_WR_DATA,
  output logic [7:0]  RD_DATA,
  output logic        BUSY,
  output logic        ERR
);

  localparam int            CW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  logic wr_interconn, wr_keydis, wr_cmd, wr_maddr, wr_mwdata;

  header_wr_decode u_decode (
    .clk_i          (SYSCLK),
    .rst_i          (RESET),
    .port_cs_i      (PORT_CS),
    .rd_wr_i        (RD_WR),
    .offset_sel_i   (OFFSET_SEL),
    .wr_interconn_o (wr_interconn),
    .wr_keydis_o    (wr_keydis),
    .wr_cmd_o       (wr_cmd),
    .wr_maddr_o     (wr_maddr),
    .wr_mwdata_o    (wr_mwdata)
  );

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    interconn_q, interconn_d;
  logic [7:0]    keydis_q, keydis_d;
  logic [7:0]    maddr_sh_q, maddr_sh_d;
  logic [7:0]    mwdata_sh_q, mwdata_sh_d;
  logic [7:0]    maddr_l_q, maddr_l_d;
  logic [7:0]    mwdata_l_q, mwdata_l_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          mem_we_q, mem_we_d;
  logic          err_q, err_d;
  logic          start_rd, start_wr, busy;

  assign start_rd = wr_cmd & DIN[CMD_RD];
  assign start_wr = wr_cmd & DIN[CMD_WR];
  assign busy     = (state_q == ST_REQ);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    interconn_d = interconn_q;
    keydis_d    = keydis_q;
    maddr_sh_d  = maddr_sh_q;
    mwdata_sh_d = mwdata_sh_q;
    maddr_l_d   = maddr_l_q;
    mwdata_l_d  = mwdata_l_q;
    rd_data_d   = rd_data_q;
    mem_we_d    = mem_we_q;
    err_d       = err_q;

    if (wr_interconn) interconn_d = DIN;
    if (wr_keydis)    keydis_d    = DIN;
    if (wr_maddr)     maddr_sh_d  = DIN;
    if (wr_mwdata)    mwdata_sh_d = DIN;
    // Clear first so a start or fault in the same cycle can re-set ERR.
    if (wr_cmd && DIN[CMD_CLR]) err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_rd && start_wr) begin
          err_d = 1'b1;
        end else if (start_rd || start_wr) begin
          state_d    = ST_REQ;
          mem_we_d   = start_wr;
          maddr_l_d  = maddr_sh_q;
          mwdata_l_d = mwdata_sh_q;
          cnt_d      = '0;
        end
      end
      ST_REQ: begin
        if (start_rd || start_wr) err_d = 1'b1;
        if (MEM_ACK) begin
          state_d = ST_IDLE;
          if (!mem_we_q) rd_data_d = MEM_RD_DATA;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      interconn_q <= INTERCONN_RST;
      keydis_q    <= KEYDIS_RST;
      maddr_sh_q  <= 8'h00;
      mwdata_sh_q <= 8'h00;
      maddr_l_q   <= 8'h00;
      mwdata_l_q  <= 8'h00;
      rd_data_q   <= 8'h00;
      mem_we_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      interconn_q <= interconn_d;
      keydis_q    <= keydis_d;
      maddr_sh_q  <= maddr_sh_d;
      mwdata_sh_q <= mwdata_sh_d;
      maddr_l_q   <= maddr_l_d;
      mwdata_l_q  <= mwdata_l_d;
      rd_data_q   <= rd_data_d;
      mem_we_q    <= mem_we_d;
      err_q       <= err_d;
    end
  end

  assign URT_INTERCONN_OUT   = interconn_q;
  assign URT_KEY_DISABLE_OUT = keydis_q;
  assign MEM_REQ             = busy;
  assign BUSY                = busy;
  assign MEM_WE              = mem_we_q;
  // In-flight operations present the launch copy, not the live shadow.
  assign MEM_ADDR            = busy ? maddr_l_q  : maddr_sh_q;
  assign MEM_WR_DATA         = busy ? mwdata_l_q : mwdata_sh_q;
  assign RD_DATA             = rd_data_q;
  assign ERR                 = err_q;

endmodule

// File: tb/tb_header_wr_ctrl.sv
// Directed bench for header_wr_ctrl with a 16-cycle memory timeout.
module tb_header_wr_ctrl;

  logic        SYSCLK = 1'b0;
  logic        RESET = 1'b0;
  logic        PORT_CS = 1'b0;
  logic [15:0] OFFSET_SEL = 16'h0000;
  logic        RD_WR = 1'b0;
  logic [7:0]  DIN = 8'h00;
  logic        MEM_ACK = 1'b0;
  logic [7:0]  MEM_RD_DATA = 8'h00;
  logic [7:0]  URT_INTERCONN_OUT, URT_KEY_DISABLE_OUT, MEM_ADDR, MEM_WR_DATA, RD_DATA;
  logic        MEM_REQ, MEM_WE, BUSY, ERR;

  int checks = 0;
  int failures = 0;

  header_wr_ctrl #(
    .INTERCONN_RST (8'h00),
    .KEYDIS_RST    (8'h00),
    .TIMEOUT_CYC   (16)
  ) dut (
    .SYSCLK              (SYSCLK),
    .RESET               (RESET),
    .PORT_CS             (PORT_CS),
    .OFFSET_SEL          (OFFSET_SEL),
    .RD_WR               (RD_WR),
    .DIN                 (DIN),
    .MEM_ACK             (MEM_ACK),
    .MEM_RD_DATA         (MEM_RD_DATA),
    .URT_INTERCONN_OUT   (URT_INTERCONN_OUT),
    .URT_KEY_DISABLE_OUT (URT_KEY_DISABLE_OUT),
    .MEM_REQ             (MEM_REQ),
    .MEM_WE              (MEM_WE),
    .MEM_ADDR            (MEM_ADDR),
    .MEM_WR_DATA         (MEM_WR_DATA),
    .RD_DATA             (RD_DATA),
    .BUSY                (BUSY),
    .ERR                 (ERR)
  );

  always #5 SYSCLK = ~SYSCLK;

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a host write and pass the commit edge; PORT_CS stays high.
  task automatic wr_start(input logic [15:0] ofs, input logic [7:0] d);
    PORT_CS = 1'b1; RD_WR = 1'b0; OFFSET_SEL = ofs; DIN = d;
    tick();
  endtask

  task automatic wr_end();
    PORT_CS = 1'b0; OFFSET_SEL = 16'h0000;
    tick();
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_interconn"}, 16'(URT_INTERCONN_OUT), 16'h00);
    chk({pfx, "_keydis"},    16'(URT_KEY_DISABLE_OUT), 16'h00);
    chk({pfx, "_mem_req"},   16'(MEM_REQ), 16'h0);
    chk({pfx, "_mem_we"},    16'(MEM_WE), 16'h0);
    chk({pfx, "_mem_addr"},  16'(MEM_ADDR), 16'h00);
    chk({pfx, "_mem_wdata"}, 16'(MEM_WR_DATA), 16'h00);
    chk({pfx, "_rd_data"},   16'(RD_DATA), 16'h00);
    chk({pfx, "_busy"},      16'(BUSY), 16'h0);
    chk({pfx, "_err"},       16'(ERR), 16'h0);
  endtask

  initial begin
    int n;

    // Reset
    RESET = 1'b1;
    tick(); tick(); tick();
    chk_reset_vals("rst");
    RESET = 1'b0;
    tick();

    // Interconnect write with a 10-cycle PORT_CS hold; DIN changes mid-hold
    wr_start(16'h0020, 8'h3C);
    chk("interconn_commit", 16'(URT_INTERCONN_OUT), 16'h3C);
    DIN = 8'h77;
    for (int i = 0; i < 9; i++) tick();
    chk("interconn_one_commit", 16'(URT_INTERCONN_OUT), 16'h3C);
    chk("keydis_untouched", 16'(URT_KEY_DISABLE_OUT), 16'h00);
    wr_end();

    // Key-disable write
    wr_start(16'h0040, 8'hC3); wr_end();
    chk("keydis_write", 16'(URT_KEY_DISABLE_OUT), 16'hC3);

    // Read operation with ack 4 cycles after MEM_REQ rises
    wr_start(16'h0100, 8'h12); wr_end();
    wr_start(16'h0080, 8'h01);
    chk("rd_req_rise", 16'(MEM_REQ), 16'h1);
    chk("rd_we", 16'(MEM_WE), 16'h0);
    chk("rd_addr", 16'(MEM_ADDR), 16'h12);
    chk("rd_busy", 16'(BUSY), 16'h1);
    wr_end();
    tick(); tick();
    chk("rd_req_held", 16'(MEM_REQ), 16'h1);
    MEM_ACK = 1'b1; MEM_RD_DATA = 8'hA7;
    tick();
    MEM_ACK = 1'b0; MEM_RD_DATA = 8'h00;
    chk("rd_req_drop", 16'(MEM_REQ), 16'h0);
    chk("rd_data", 16'(RD_DATA), 16'hA7);
    chk("rd_busy_done", 16'(BUSY), 16'h0);
    chk("rd_err", 16'(ERR), 16'h0);

    // Write operation that times out after 16 request cycles
    wr_start(16'h0200, 8'h5A); wr_end();
    wr_start(16'h0080, 8'h02);
    PORT_CS = 1'b0; OFFSET_SEL = 16'h0000;
    chk("wr_we", 16'(MEM_WE), 16'h1);
    chk("wr_wdata", 16'(MEM_WR_DATA), 16'h5A);
    n = 0;
    while (MEM_REQ === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    chk("timeout_req_cycles", 16'(n), 16'd16);
    chk("timeout_err", 16'(ERR), 16'h1);
    chk("timeout_busy", 16'(BUSY), 16'h0);
    chk("timeout_rd_data_kept", 16'(RD_DATA), 16'hA7);
    tick();
    wr_start(16'h0080, 8'h80); wr_end();
    chk("err_clear", 16'(ERR), 16'h0);

    // Start and address write while busy
    wr_start(16'h0100, 8'h33); wr_end();
    wr_start(16'h0080, 8'h01); wr_end();
    wr_start(16'h0080, 8'h01);
    chk("busy_start_err", 16'(ERR), 16'h1);
    chk("busy_start_still_busy", 16'(BUSY), 16'h1);
    wr_end();
    wr_start(16'h0100, 8'h55);
    chk("busy_addr_launch", 16'(MEM_ADDR), 16'h33);
    wr_end();
    MEM_ACK = 1'b1; MEM_RD_DATA = 8'h44;
    tick();
    MEM_ACK = 1'b0;
    chk("busy_done_addr_shadow", 16'(MEM_ADDR), 16'h55);
    chk("busy_done_rd_data", 16'(RD_DATA), 16'h44);
    chk("busy_done_err_sticky", 16'(ERR), 16'h1);

    // MEM_ACK in IDLE is ignored
    MEM_ACK = 1'b1; MEM_RD_DATA = 8'h99;
    tick();
    MEM_ACK = 1'b0;
    chk("idle_ack_ignored", 16'(RD_DATA), 16'h44);

    // Both start bits: ERR, no launch
    wr_start(16'h0080, 8'h80); wr_end();
    chk("clr_before_both", 16'(ERR), 16'h0);
    wr_start(16'h0080, 8'h03);
    chk("both_err", 16'(ERR), 16'h1);
    chk("both_no_req", 16'(MEM_REQ), 16'h0);
    wr_end();
    chk("both_no_req_later", 16'(MEM_REQ), 16'h0);

    // Two offset bits set: nothing changes
    wr_start(16'h0060, 8'hFF); wr_end();
    chk("multi_interconn", 16'(URT_INTERCONN_OUT), 16'h3C);
    chk("multi_keydis", 16'(URT_KEY_DISABLE_OUT), 16'hC3);

    // Clear+start in one byte, then reset mid-operation
    wr_start(16'h0080, 8'h82);
    chk("clr_start_err", 16'(ERR), 16'h0);
    chk("clr_start_req", 16'(MEM_REQ), 16'h1);
    chk("clr_start_we", 16'(MEM_WE), 16'h1);
    wr_end();
    RESET = 1'b1;
    tick();
    chk_reset_vals("midrst");
    RESET = 1'b0;
    MEM_ACK = 1'b1; MEM_RD_DATA = 8'hEE;
    tick();
    MEM_ACK = 1'b0;
    tick();
    chk("late_ack_rd_data", 16'(RD_DATA), 16'h00);
    chk("late_ack_busy", 16'(BUSY), 16'h0);
    chk("late_ack_req", 16'(MEM_REQ), 16'h0);
    chk("late_ack_err", 16'(ERR), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/header_wr_ctrl.md
Name: header_wr_ctrl

Overview:
- Write-side companion of the status CPLD register header block.
- Decodes I2C host writes (PORT_CS with RD_WR=0) into the writable registers: interconnect 0xA5, key-disable 0xA6, plus memory address, write-data and command registers.
- Runs a request/acknowledge state machine toward the external memory port.
- Returns BUSY, ERR and the captured read byte, which the read-side header muxes back to the host.

Parameters:
- INTERCONN_RST, 8'h00, reset value of URT_INTERCONN_OUT
- KEYDIS_RST, 8'h00, reset value of URT_KEY_DISABLE_OUT
- TIMEOUT_CYC, 255, SYSCLK cycles to wait for MEM_ACK before flagging ERR (1..65535)

Ports:
- SYSCLK  in  1  system clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- PORT_CS  in  1  port select from the I2C slave
- OFFSET_SEL  in  16  one-hot offset select
- RD_WR  in  1  1=read, 0=write
- DIN  in  8  host write byte
- MEM_ACK  in  1  memory done, one-cycle pulse
- MEM_RD_DATA  in  8  memory read byte, valid with MEM_ACK
- URT_INTERCONN_OUT  out  8  register at OFFSET_SEL[5]
- URT_KEY_DISABLE_OUT  out  8  register at OFFSET_SEL[6]
- MEM_REQ  out  1  memory request, held until ack or timeout
- MEM_WE  out  1  1=write op, 0=read op; stable while MEM_REQ=1
- MEM_ADDR  out  8  register at OFFSET_SEL[8]
- MEM_WR_DATA  out  8  register at OFFSET_SEL[9]
- RD_DATA  out  8  last memory read byte
- BUSY  out  1  operation in progress
- ERR  out  1  sticky error

Behaviour:
- Reset: URT_INTERCONN_OUT=INTERCONN_RST; URT_KEY_DISABLE_OUT=KEYDIS_RST; MEM_ADDR, MEM_WR_DATA, RD_DATA=8'h00; MEM_REQ, MEM_WE, BUSY, ERR=0; FSM=IDLE; timeout counter=0.
- Reset has priority over everything. Reset mid-operation drops MEM_REQ on the next edge; a late MEM_ACK is then ignored.
- Write qualifier: wq = PORT_CS & ~RD_WR, registered as wq_d.
- Commit: on the cycle where wq=1 and wq_d=0. This gives exactly one commit per host write, however long PORT_CS is held.
- Commit targets the single OFFSET_SEL bit set. If zero bits or more than one bit is set, the commit is ignored; no register changes.
- Register update happens on the commit edge and is visible the following cycle.
- Writes to offsets 5, 6, 8 and 9 always update, even while BUSY.
  - A write to 8 or 9 while BUSY does not change the in-flight MEM_ADDR/MEM_WR_DATA, which are latched at launch.
  - MEM_ADDR/MEM_WR_DATA outputs show the launch copy while BUSY and the shadow copy otherwise.
- Command register, OFFSET_SEL[7], write-only:
  - DIN[0] = start read; DIN[1] = start write; DIN[7] = clear ERR.
  - ERR clear applies first; a start in the same byte then proceeds.
  - DIN[1:0]=2'b11 sets ERR=1 and launches nothing.
  - Any start while BUSY=1 sets ERR=1 and is otherwise ignored.
- FSM states:
  - IDLE: on a valid start commit, set BUSY=1, latch MEM_WE and the address/data on the same edge, clear the counter, go to REQ.
  - REQ: MEM_REQ=1, starting one cycle after the commit. Counter increments each cycle.
    - MEM_ACK=1: MEM_REQ=0; if read, RD_DATA<=MEM_RD_DATA; go to IDLE with BUSY=0. Data is visible the next cycle.
    - Counter reaches TIMEOUT_CYC-1 without ack: MEM_REQ=0, ERR=1, BUSY=0, go to IDLE. RD_DATA is unchanged.
    - MEM_ACK on the same cycle as timeout: ack wins, no ERR.
- MEM_ACK while in IDLE is ignored.
- Counter width is clog2(TIMEOUT_CYC+1). It saturates and never wraps.
- ERR stays set until a DIN[7] command or reset.

Decomposition:
- Shared package/header holds:
  - offset bit indices: INTERCONN=5, KEYDIS=6, CMD=7, MADDR=8, MWDATA=9
  - command bit positions: RD=0, WR=1, CLR=7
  - FSM state encodings: IDLE, REQ
- One natural sub-module, header_wr_decode. It contains the wq edge detect, the one-hot check and the per-offset write strobes. The FSM and registers stay in the top.

Test Plan:
- Reset, then host write DIN=8'h3C at OFFSET_SEL=16'h0020 with PORT_CS held 10 cycles -> URT_INTERCONN_OUT=8'h3C one cycle after the wq rise; exactly one commit; URT_KEY_DISABLE_OUT stays 8'h00.
- Write MADDR=8'h12, then CMD=8'h01; MEM_ACK pulses 4 cycles after MEM_REQ rises with MEM_RD_DATA=8'hA7 -> MEM_REQ=1 at commit+1 with MEM_WE=0 and MEM_ADDR=8'h12; on ack, RD_DATA=8'hA7, BUSY=0, ERR=0.
- TIMEOUT_CYC=16: CMD=8'h02 with no ack -> MEM_REQ high for 16 cycles then low; ERR=1, BUSY=0. A later CMD=8'h80 -> ERR=0.
- While BUSY: CMD=8'h01 and MADDR=8'h55 -> ERR=1, MEM_ADDR stays at the launch value until done, then shows 8'h55.
- CMD=8'h03 -> ERR=1, MEM_REQ never asserts. OFFSET_SEL=16'h0060 with DIN=8'hFF -> neither register changes.
- Assert RESET while MEM_REQ=1 -> all outputs at reset values the next cycle; a MEM_ACK pulse afterwards changes nothing.
